// File: rtl/squeeze_stream_if.sv
// AXI-Stream output bundle for the squeeze unit.
// master drives the beat; slave returns tready.
interface squeeze_stream_if #(
  parameter int OUT_DWIDTH = 256
);
  logic [OUT_DWIDTH-1:0]   tdata;
  logic [OUT_DWIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/squeeze_stream_unit.sv
// Keccak squeeze phase: walks the rate, emits AXI-Stream beats, requests permutations.
// Optional SQUEEZE_STATS_EN adds bytes_total_o / perm_count_o session counters.
module squeeze_stream_unit #(
  parameter int OUT_DWIDTH = 256,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [7:0]           rate_bytes_i,
  input  logic [LEN_WIDTH-1:0] out_len_i,
  input  logic                 abort_i,
  input  logic [1599:0]        state_array_i,
  output logic                 perm_req_o,
  input  logic                 perm_done_i,
  squeeze_stream_if.master     m_axis,
`ifdef SQUEEZE_STATS_EN
  output logic [LEN_WIDTH+7:0] bytes_total_o,
  output logic [15:0]          perm_count_o,
`endif
  output logic                 busy_o
);
  localparam int         BB  = OUT_DWIDTH / 8;
  localparam logic [7:0] BB8 = 8'(BB);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_STREAM    = 2'd1;
  localparam logic [1:0] S_PERM_WAIT = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [7:0]           rate_q, rate_d;
  logic [7:0]           offset_q, offset_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 bounded_q, bounded_d;
  logic                 perm_req_q, perm_req_d;

  logic                 is_stream, fire, last, rollover, start_ok;
  logic [7:0]           rate_left, n_rate, n_beat, offset_nxt;

  // Zero-padded byte view so reads past byte 199 fall on constant zeros.
  logic [511:0][7:0]    ext;
  logic [BB-1:0][7:0]   beat;
  assign ext = {{(4096-1600){1'b0}}, state_array_i};

  for (genvar b = 0; b < BB; b++) begin : g_byte
    logic [8:0] idx;
    assign idx                = {1'b0, offset_q} + 9'(b);
    assign beat[b]            = ext[idx];
    assign m_axis.tkeep[b]    = is_stream && (8'(b) < n_beat);
  end

  assign is_stream  = (state_q == S_STREAM);
  assign rate_left  = rate_q - offset_q;
  assign n_rate     = (rate_left < BB8) ? rate_left : BB8;
  assign n_beat     = (bounded_q && (remaining_q < LEN_WIDTH'(n_rate))) ? remaining_q[7:0] : n_rate;
  assign last       = bounded_q && (LEN_WIDTH'(n_beat) == remaining_q);
  assign offset_nxt = offset_q + n_beat;
  assign fire       = is_stream && m_axis.tready;
  assign rollover   = fire && !last && (offset_nxt == rate_q);
  assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i;

  assign m_axis.tvalid = is_stream;
  assign m_axis.tdata  = is_stream ? beat : '0;
  assign m_axis.tlast  = is_stream && last;
  assign perm_req_o    = perm_req_q;
  assign busy_o        = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    bounded_d   = bounded_q;
    perm_req_d  = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          rate_d      = rate_bytes_i;
          remaining_d = out_len_i;
          bounded_d   = (out_len_i != '0);
          offset_d    = '0;
          state_d     = S_STREAM;
        end
        S_STREAM: if (fire) begin
          if (bounded_q) remaining_d = remaining_q - LEN_WIDTH'(n_beat);
          offset_d = offset_nxt;
          if (last) begin
            state_d = S_IDLE;
          end else if (rollover) begin
            offset_d   = '0;
            perm_req_d = 1'b1;
            state_d    = S_PERM_WAIT;
          end
        end
        S_PERM_WAIT: if (perm_done_i) state_d = S_STREAM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      rate_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      bounded_q   <= 1'b0;
      perm_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      bounded_q   <= bounded_d;
      perm_req_q  <= perm_req_d;
    end
  end

`ifdef SQUEEZE_STATS_EN
  logic [LEN_WIDTH+7:0] bytes_total_q;
  logic [15:0]          perm_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bytes_total_q <= '0;
      perm_count_q  <= '0;
    end else if (start_ok) begin
      bytes_total_q <= '0;
      perm_count_q  <= '0;
    end else begin
      if (fire && !abort_i) bytes_total_q <= bytes_total_q + (LEN_WIDTH+8)'(n_beat);
      if (perm_req_d && (perm_count_q != 16'hFFFF)) perm_count_q <= perm_count_q + 16'd1;
    end
  end

  assign bytes_total_o = bytes_total_q;
  assign perm_count_o  = perm_count_q;
`endif
endmodule
